mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters: sizeVal, default 32, data/address width; sizeAd, default 5, register-file address width; TIMEOUT, default 15, maximum wait cycles for mem_ack.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset: synchronous, active-high.
REQ-004 RFWEM, MtoRFSelM, DMWEM  in  1 each  memory-stage controls: register write enable, load select, store enable.
REQ-005 RFAM  in  sizeAd  destination register address.
REQ-006 ALUOutM, DMdinM  in  sizeVal  memory address / ALU result; store data.
REQ-007 mem_req, mem_we  out  1 each  data-memory request; write qualifier.
REQ-008 mem_addr, mem_wdata  out  sizeVal  request address (= ALUOutM); write data (= DMdinM).
REQ-009 mem_rdata  in  sizeVal  read data, valid in the mem_ack cycle.
REQ-010 mem_ack  in  1  request completion; may assert in the first mem_req cycle.
REQ-011 stallM  out  1  freezes the upstream execute/memory pipeline register and all earlier stages.
REQ-012 RFWEW, MtoRFSelW  out  1 each  writeback controls.
REQ-013 RFAW  out  sizeAd  writeback destination.
REQ-014 ALUOutW, DMOutW, ResultW  out  sizeVal  registered ALU result; registered load data; combinational writeback mux output.
REQ-015 err_timeout, err_align  out  1 each  sticky error flags.

Function
REQ-016 Memory op: MtoRFSelM=1 (load) or DMWEM=1 (store); both=1 is treated as a store.
REQ-017 FSM states: IDLE, BUSY.
- IDLE + memory op + aligned + no ack -> BUSY.
- BUSY + mem_ack -> IDLE.
- BUSY + timeout -> IDLE.
REQ-018 mem_req=1 when either:
- IDLE with an aligned memory op; or
- BUSY.
REQ-019 While mem_req=1:
- mem_we = DMWEM.
- mem_addr and mem_wdata are held stable; this relies on the upstream register being frozen by stallM.
REQ-020 stallM = mem_req AND NOT mem_ack, excluding the timeout cycle; a zero-wait ack gives a single-cycle memory op with no stall.
REQ-021 Non-memory op in IDLE: the writeback register captures RFWEM, MtoRFSelM, RFAM, ALUOutM on the next edge; latency 1 cycle.
REQ-022 Memory op completion: on the mem_ack edge the writeback register captures:
- the controls, with RFWEW=RFWEM for loads and RFWEW=0 for stores;
- DMOutW <= mem_rdata for loads; DMOutW holds its previous value for stores.
REQ-023 Every stall cycle loads a bubble into the writeback register: RFWEW=0, MtoRFSelW=0, RFAW=0; data fields hold their values.
REQ-024 ResultW = DMOutW if MtoRFSelW=1, else ALUOutW.
REQ-025 Wait counter:
- cleared on entering BUSY; increments each BUSY cycle without ack.
- on reaching TIMEOUT: drop mem_req, deassert stallM, set err_timeout, insert a bubble, return to IDLE.
REQ-026 Misalignment: a memory op with ALUOutM[1:0] != 0 issues no request, inserts a bubble, sets err_align and causes no stall.
REQ-027 mem_ack outside a request is ignored.
REQ-028 The error flags clear only on reset.

Reset
REQ-029 rst=1 forces on the next edge:
- state IDLE, wait counter 0;
- all writeback outputs 0, both error flags 0.
REQ-030 While rst=1, mem_req and stallM are 0.
REQ-031 rst asserted during BUSY abandons the request; the edge after rst deasserts behaves as IDLE.

Verification
REQ-032 ALU op RFWEM=1, RFAM=3, ALUOutM=0x10 -> next cycle RFWEW=1, RFAW=3, ResultW=0x10, stallM=0 throughout.
REQ-033 Load at 0x20, mem_ack in the first cycle, mem_rdata=0xDEADBEEF -> no stall; next cycle ResultW=0xDEADBEEF, MtoRFSelW=1.
REQ-034 Store at 0x40 of 0x55, mem_ack after 3 cycles -> stallM=1 for 3 cycles; mem_we=1 with stable address and data; bubbles during the stall; RFWEW=0 at completion.
REQ-035 Load with no ack, TIMEOUT=15 -> stallM falls after 15 BUSY cycles, err_timeout=1, bubble delivered.
REQ-036 Load at 0x22 -> mem_req never asserts, err_align=1, bubble delivered.
REQ-037 rst pulse in the 2nd BUSY cycle -> mem_req=0 and all outputs 0 after the edge; a following ALU op completes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage with a req/ack data-memory handshake and the MEM/WB pipeline register.
// Stalls upstream while a request is outstanding, and flags timeouts and misaligned accesses.
module mem_wb_stage #(
  parameter int sizeVal = 32,
  parameter int sizeAd  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RFWEM,
  input  logic               MtoRFSelM,
  input  logic               DMWEM,
  input  logic [sizeAd-1:0]  RFAM,
  input  logic [sizeVal-1:0] ALUOutM,
  input  logic [sizeVal-1:0] DMdinM,
  output logic               mem_req,
  output logic               mem_we,
  output logic [sizeVal-1:0] mem_addr,
  output logic [sizeVal-1:0] mem_wdata,
  input  logic [sizeVal-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               stallM,
  output logic               RFWEW,
  output logic               MtoRFSelW,
  output logic [sizeAd-1:0]  RFAW,
  output logic [sizeVal-1:0] ALUOutW,
  output logic [sizeVal-1:0] DMOutW,
  output logic [sizeVal-1:0] ResultW,
  output logic               err_timeout,
  output logic               err_align
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rfwe_q, rfwe_d;
  logic                mtorf_q, mtorf_d;
  logic [sizeAd-1:0]   rfa_q, rfa_d;
  logic [sizeVal-1:0]  alu_q, alu_d;
  logic [sizeVal-1:0]  dmout_q, dmout_d;
  logic                err_to_q, err_to_d;
  logic                err_al_q, err_al_d;

  logic mem_op, aligned, req, stall;

  assign mem_op  = MtoRFSelM | DMWEM;
  assign aligned = (ALUOutM[1:0] == 2'b00);

  // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rfwe_d   = rfwe_q;
    mtorf_d  = mtorf_q;
    rfa_d    = rfa_q;
    alu_d    = alu_q;
    dmout_d  = dmout_q;
    err_to_d = err_to_q;
    err_al_d = err_al_q;
    req      = 1'b0;
    stall    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          rfwe_d  = RFWEM;
          mtorf_d = MtoRFSelM;
          rfa_d   = RFAM;
          alu_d   = ALUOutM;
        end else if (!aligned) begin
          rfwe_d   = 1'b0;
          mtorf_d  = 1'b0;
          rfa_d    = '0;
          err_al_d = 1'b1;
        end else begin
          req = 1'b1;
          if (!mem_ack) begin
            stall   = 1'b1;
            rfwe_d  = 1'b0;
            mtorf_d = 1'b0;
            rfa_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CW'(TIMEOUT)) begin
          // Give up: release the pipeline and drop the instruction as a bubble.
          rfwe_d   = 1'b0;
          mtorf_d  = 1'b0;
          rfa_d    = '0;
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          req = 1'b1;
          if (mem_ack) begin
            state_d = IDLE;
          end else begin
            stall   = 1'b1;
            rfwe_d  = 1'b0;
            mtorf_d = 1'b0;
            rfa_d   = '0;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Completing edge: a store never writes the register file, and keeps the old load data.
    if (req && mem_ack) begin
      rfwe_d  = RFWEM & ~DMWEM;
      mtorf_d = MtoRFSelM & ~DMWEM;
      rfa_d   = RFAM;
      alu_d   = ALUOutM;
      if (!DMWEM) dmout_d = mem_rdata;
    end

    if (rst) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rfwe_q   <= 1'b0;
      mtorf_q  <= 1'b0;
      rfa_q    <= '0;
      alu_q    <= '0;
      dmout_q  <= '0;
      err_to_q <= 1'b0;
      err_al_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rfwe_q   <= rfwe_d;
      mtorf_q  <= mtorf_d;
      rfa_q    <= rfa_d;
      alu_q    <= alu_d;
      dmout_q  <= dmout_d;
      err_to_q <= err_to_d;
      err_al_q <= err_al_d;
    end
  end

  assign mem_req     = req;
  assign mem_we      = req & DMWEM;
  assign mem_addr    = ALUOutM;
  assign mem_wdata   = DMdinM;
  assign stallM      = stall;
  assign RFWEW       = rfwe_q;
  assign MtoRFSelW   = mtorf_q;
  assign RFAW        = rfa_q;
  assign ALUOutW     = alu_q;
  assign DMOutW      = dmout_q;
  assign ResultW     = mtorf_q ? dmout_q : alu_q;
  assign err_timeout = err_to_q;
  assign err_align   = err_al_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU op, zero-wait load, waited store, timeout,
// misalignment, stray ack and reset during a request, with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RFWEM, MtoRFSelM, DMWEM;
  logic [4:0]  RFAM;
  logic [31:0] ALUOutM, DMdinM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, stallM;
  logic        RFWEW, MtoRFSelW;
  logic [4:0]  RFAW;
  logic [31:0] ALUOutW, DMOutW, ResultW;
  logic        err_timeout, err_align;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage #(.sizeVal(32), .sizeAd(5), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .DMWEM(DMWEM), .RFAM(RFAM),
    .ALUOutM(ALUOutM), .DMdinM(DMdinM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stallM(stallM),
    .RFWEW(RFWEW), .MtoRFSelW(MtoRFSelW), .RFAW(RFAW),
    .ALUOutW(ALUOutW), .DMOutW(DMOutW), .ResultW(ResultW),
    .err_timeout(err_timeout), .err_align(err_align)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic ld, input logic st, input logic [4:0] a,
                       input logic [31:0] alu, input logic [31:0] din,
                       input logic [31:0] rd, input logic ack);
    RFWEM = we; MtoRFSelM = ld; DMWEM = st; RFAM = a;
    ALUOutM = alu; DMdinM = din; mem_rdata = rd; mem_ack = ack;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Reset state, and no request while rst is high even with a load presented
    check("rst_rfwew", RFWEW, 0);
    check("rst_rfaw", RFAW, 0);
    check("rst_result", ResultW, 0);
    check("rst_err_to", err_timeout, 0);
    check("rst_err_al", err_align, 0);
    drive(1, 1, 0, 5'd3, 32'h20, 0, 0, 1);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_stall", stallM, 0);
    tick();
    rst = 1'b0;

    // ALU op
    drive(1, 0, 0, 5'd3, 32'h10, 0, 0, 0);
    #1;
    check("alu_stall", stallM, 0);
    check("alu_req", mem_req, 0);
    tick();
    check("alu_rfwew", RFWEW, 1);
    check("alu_rfaw", RFAW, 3);
    check("alu_result", ResultW, 32'h10);

    // Zero-wait load
    drive(1, 1, 0, 5'd7, 32'h20, 0, 32'hDEADBEEF, 1);
    #1;
    check("ld0_req", mem_req, 1);
    check("ld0_we", mem_we, 0);
    check("ld0_stall", stallM, 0);
    check("ld0_addr", mem_addr, 32'h20);
    tick();
    check("ld0_result", ResultW, 32'hDEADBEEF);
    check("ld0_mtorf", MtoRFSelW, 1);
    check("ld0_rfwew", RFWEW, 1);
    check("ld0_rfaw", RFAW, 7);

    // Store with three stall cycles; junk read data must not be captured
    drive(1, 0, 1, 5'd9, 32'h40, 32'h55, 32'h12345678, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_stall", stallM, 1);
      check("st_req", mem_req, 1);
      check("st_we", mem_we, 1);
      check("st_addr", mem_addr, 32'h40);
      check("st_wdata", mem_wdata, 32'h55);
      tick();
      check("st_bub_rfwew", RFWEW, 0);
      check("st_bub_rfaw", RFAW, 0);
      check("st_bub_mtorf", MtoRFSelW, 0);
      check("st_bub_dmout", DMOutW, 32'hDEADBEEF);
    end
    check("st_bub_alu_hold", ALUOutW, 32'h20);
    mem_ack = 1'b1;
    #1;
    check("st_ack_stall", stallM, 0);
    check("st_ack_we", mem_we, 1);
    tick();
    check("st_done_rfwew", RFWEW, 0);
    check("st_done_rfaw", RFAW, 9);
    check("st_done_alu", ALUOutW, 32'h40);
    check("st_done_dmout", DMOutW, 32'hDEADBEEF);
    check("st_done_result", ResultW, 32'h40);

    // Load with no ack: 1 issue cycle + 15 BUSY cycles stalled, then release
    drive(1, 1, 0, 5'd4, 32'h80, 0, 32'hCAFE, 0);
    for (int i = 0; i < 16; i++) begin
      #1;
      check("to_stall", stallM, 1);
      tick();
    end
    mem_ack = 1'b1;   // arrives with no request outstanding
    #1;
    check("to_stall_drop", stallM, 0);
    check("to_req_drop", mem_req, 0);
    check("to_err_pre", err_timeout, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    check("to_err", err_timeout, 1);
    check("to_bub_rfwew", RFWEW, 0);
    check("to_bub_rfaw", RFAW, 0);
    check("to_dmout_hold", DMOutW, 32'hDEADBEEF);
    check("to_err_al", err_align, 0);

    // Misaligned load
    drive(1, 1, 0, 5'd5, 32'h22, 0, 0, 0);
    #1;
    check("al_req", mem_req, 0);
    check("al_stall", stallM, 0);
    tick();
    check("al_err", err_align, 1);
    check("al_rfwew", RFWEW, 0);
    check("al_rfaw", RFAW, 0);
    check("al_err_to_sticky", err_timeout, 1);

    // Stray ack during an ALU op is ignored
    drive(1, 0, 0, 5'd2, 32'h33, 0, 32'h99, 1);
    #1;
    check("stray_req", mem_req, 0);
    tick();
    check("stray_result", ResultW, 32'h33);
    check("stray_dmout", DMOutW, 32'hDEADBEEF);
    check("stray_rfaw", RFAW, 2);

    // Reset in the second BUSY cycle, then an ALU op
    drive(1, 1, 0, 5'd6, 32'h100, 0, 0, 0);
    tick(); tick();
    #1;
    check("rb_busy_req", mem_req, 1);
    rst = 1'b1;
    drive(1, 0, 0, 5'd1, 32'h44, 0, 0, 0);
    #1;
    check("rb_rst_req", mem_req, 0);
    check("rb_rst_stall", stallM, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rb_rfwew", RFWEW, 0);
    check("rb_rfaw", RFAW, 0);
    check("rb_result", ResultW, 0);
    check("rb_err_to", err_timeout, 0);
    check("rb_err_al", err_align, 0);
    check("rb_req", mem_req, 0);
    check("rb_stall", stallM, 0);
    tick();
    check("rb_alu_rfwew", RFWEW, 1);
    check("rb_alu_rfaw", RFAW, 1);
    check("rb_alu_result", ResultW, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
